// File: rtl/isq_pkg.sv
// Shared sizing, issue-register state type and bit-vector helpers for the
// issue-queue slot controller.
package isq_pkg;

    localparam int DEPTH = 8;
    localparam int LOG   = $clog2(DEPTH);

    typedef enum logic {
        ISSUE_EMPTY,
        ISSUE_HELD
    } issue_state_t;

    function automatic logic [DEPTH-1:0] ffs_lowest_zero(input logic [DEPTH-1:0] vec);
        logic [DEPTH-1:0] result;
        result = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vec[i]) begin
                result    = '0;
                result[i] = 1'b1;
            end
        end
        return result;
    endfunction

    // OR-encoder: exact for one-hot input, zero for an all-zero input.
    function automatic logic [LOG-1:0] oh2idx(input logic [DEPTH-1:0] oh);
        logic [LOG-1:0] idx;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (oh[i]) begin
                idx = idx | LOG'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/isq_free_slot_pick.sv
// Combinational lowest-free-slot finder over the issue-queue valid bitmap.
module isq_free_slot_pick
    import isq_pkg::*;
(
    input  logic [DEPTH-1:0] valid,
    output logic [DEPTH-1:0] free_oh,
    output logic [LOG-1:0]   enq_ptr,
    output logic             any_free
);

    assign free_oh  = ffs_lowest_zero(valid);
    assign enq_ptr  = oh2idx(free_oh);
    assign any_free = ~&valid;

endmodule

// File: rtl/isq_slot_ctrl.sv
// Issue-queue slot controller: valid bitmap, occupancy count, slot allocation
// and a one-deep issue register with valid/ready handshake.
module isq_slot_ctrl
    import isq_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    output logic [DEPTH-1:0] iq_entries_wren_oh,
    output logic [LOG-1:0]   enq_ptr,
    output logic [DEPTH-1:0] iq_entries_valid,
    input  logic [DEPTH-1:0] iq_entries_ready_to_go,
    input  logic             oldest_found,
    input  logic [DEPTH-1:0] oldest_idx_oh,
    output logic [DEPTH-1:0] iq_entries_clear_entry,
    output logic [LOG-1:0]   deq_ptr,
    output logic             deq_fire,
    output logic             issue_valid,
    output logic [LOG-1:0]   issue_idx,
    input  logic             issue_ready,
    output logic [LOG:0]     iq_count,
    output logic             iq_full,
    output logic             iq_empty
);

    logic [DEPTH-1:0] free_oh;
    logic [DEPTH-1:0] cand;
    logic [LOG-1:0]   pick_ptr;
    logic             any_free;
    logic             enq_fire;
    issue_state_t     issue_state;

    isq_free_slot_pick u_free_slot_pick (
        .valid    (iq_entries_valid),
        .free_oh  (free_oh),
        .enq_ptr  (pick_ptr),
        .any_free (any_free)
    );

    assign iq_full  = (iq_count == (LOG+1)'(DEPTH));
    assign iq_empty = (iq_count == '0);

    // Enqueue sees only registered occupancy, so a same-cycle dequeue never frees a slot.
    assign enq_ready          = !reset && !flush && !iq_full && any_free;
    assign enq_fire           = enq_valid && enq_ready;
    assign iq_entries_wren_oh = enq_fire ? free_oh : '0;
    assign enq_ptr            = reset ? '0 : pick_ptr;

    // The age pick is not ready-qualified, so mask it with ready and valid here.
    assign cand                   = oldest_idx_oh & iq_entries_ready_to_go & iq_entries_valid;
    assign deq_fire               = !reset && !flush && oldest_found && (|cand)
                                    && (!issue_valid || issue_ready);
    assign iq_entries_clear_entry = deq_fire ? cand : '0;
    assign deq_ptr                = deq_fire ? oh2idx(cand) : '0;

    assign issue_valid = (issue_state == ISSUE_HELD);

    always_ff @(posedge clock) begin
        if (reset) begin
            iq_entries_valid <= '0;
            iq_count         <= '0;
            issue_state      <= ISSUE_EMPTY;
            issue_idx        <= '0;
        end else if (flush) begin
            iq_entries_valid <= '0;
            iq_count         <= '0;
            issue_state      <= ISSUE_EMPTY;
        end else begin
            iq_entries_valid <= (iq_entries_valid | iq_entries_wren_oh) & ~iq_entries_clear_entry;
            iq_count         <= iq_count + (LOG+1)'(enq_fire) - (LOG+1)'(deq_fire);
            case (issue_state)
                ISSUE_EMPTY: begin
                    if (deq_fire) begin
                        issue_state <= ISSUE_HELD;
                        issue_idx   <= deq_ptr;
                    end
                end
                ISSUE_HELD: begin
                    if (deq_fire) begin
                        issue_idx <= deq_ptr;
                    end else if (issue_ready) begin
                        issue_state <= ISSUE_EMPTY;
                    end
                end
                default: issue_state <= ISSUE_EMPTY;
            endcase
        end
    end

    a_cand_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(cand));
    a_count_pop:   assert property (@(posedge clock) disable iff (reset)
                       iq_count == (LOG+1)'($countones(iq_entries_valid)));
    a_no_enq_full: assert property (@(posedge clock) disable iff (reset) !(enq_fire && iq_full));
    a_disjoint:    assert property (@(posedge clock) disable iff (reset)
                       (iq_entries_wren_oh & iq_entries_clear_entry) == '0);

endmodule

// File: tb/tb_isq_slot_ctrl.sv
// Directed, table-driven bench for isq_slot_ctrl with hand-written sequences
// for backpressure, flush and mid-traffic reset.
module tb_isq_slot_ctrl;
    import isq_pkg::*;

    logic             clock = 1'b0;
    logic             reset;
    logic             flush;
    logic             enq_valid;
    logic             enq_ready;
    logic [DEPTH-1:0] iq_entries_wren_oh;
    logic [LOG-1:0]   enq_ptr;
    logic [DEPTH-1:0] iq_entries_valid;
    logic [DEPTH-1:0] iq_entries_ready_to_go;
    logic             oldest_found;
    logic [DEPTH-1:0] oldest_idx_oh;
    logic [DEPTH-1:0] iq_entries_clear_entry;
    logic [LOG-1:0]   deq_ptr;
    logic             deq_fire;
    logic             issue_valid;
    logic [LOG-1:0]   issue_idx;
    logic             issue_ready;
    logic [LOG:0]     iq_count;
    logic             iq_full;
    logic             iq_empty;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    isq_slot_ctrl dut (
        .clock                  (clock),
        .reset                  (reset),
        .flush                  (flush),
        .enq_valid              (enq_valid),
        .enq_ready              (enq_ready),
        .iq_entries_wren_oh     (iq_entries_wren_oh),
        .enq_ptr                (enq_ptr),
        .iq_entries_valid       (iq_entries_valid),
        .iq_entries_ready_to_go (iq_entries_ready_to_go),
        .oldest_found           (oldest_found),
        .oldest_idx_oh          (oldest_idx_oh),
        .iq_entries_clear_entry (iq_entries_clear_entry),
        .deq_ptr                (deq_ptr),
        .deq_fire               (deq_fire),
        .issue_valid            (issue_valid),
        .issue_idx              (issue_idx),
        .issue_ready            (issue_ready),
        .iq_count               (iq_count),
        .iq_full                (iq_full),
        .iq_empty               (iq_empty)
    );

    typedef struct {
        logic       enq_valid;
        logic       flush;
        logic [7:0] rtg;
        logic       found;
        logic [7:0] oldest;
        logic       issue_ready;
        logic       x_enq_ready;
        logic [7:0] x_wren;
        logic [2:0] x_enq_ptr;
        logic       x_deq_fire;
        logic [2:0] x_deq_ptr;
        logic [7:0] x_clear;
        logic [3:0] x_count;
        logic [7:0] x_valid;
        logic       x_issue_valid;
        logic [2:0] x_issue_idx;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(
        input logic ev, input logic fl, input logic [7:0] rtg, input logic of,
        input logic [7:0] ooh, input logic ir, input logic xer, input logic [7:0] xw,
        input logic [2:0] xep, input logic xdf, input logic [2:0] xdp, input logic [7:0] xcl,
        input logic [3:0] xcnt, input logic [7:0] xval, input logic xiv, input logic [2:0] xidx);
        vec_t v;
        v.enq_valid = ev;  v.flush = fl;  v.rtg = rtg;  v.found = of;
        v.oldest = ooh;  v.issue_ready = ir;  v.x_enq_ready = xer;  v.x_wren = xw;
        v.x_enq_ptr = xep;  v.x_deq_fire = xdf;  v.x_deq_ptr = xdp;  v.x_clear = xcl;
        v.x_count = xcnt;  v.x_valid = xval;  v.x_issue_valid = xiv;  v.x_issue_idx = xidx;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic ev, input logic fl, input logic [7:0] rtg,
                                 input logic of, input logic [7:0] ooh, input logic ir);
        @(negedge clock);
        enq_valid              = ev;
        flush                  = fl;
        iq_entries_ready_to_go = rtg;
        oldest_found           = of;
        oldest_idx_oh          = ooh;
        issue_ready            = ir;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input vec_t v);
        check("enq_ready", 32'(enq_ready), 32'(v.x_enq_ready));
        check("wren_oh", 32'(iq_entries_wren_oh), 32'(v.x_wren));
        if (v.x_enq_ready) check("enq_ptr", 32'(enq_ptr), 32'(v.x_enq_ptr));
        check("deq_fire", 32'(deq_fire), 32'(v.x_deq_fire));
        if (v.x_deq_fire) check("deq_ptr", 32'(deq_ptr), 32'(v.x_deq_ptr));
        check("clear_entry", 32'(iq_entries_clear_entry), 32'(v.x_clear));
    endtask

    task automatic checkState(input logic [3:0] cnt, input logic [7:0] val,
                              input logic iv, input logic [2:0] idx);
        check("iq_count", 32'(iq_count), 32'(cnt));
        check("valid_map", 32'(iq_entries_valid), 32'(val));
        check("iq_full", 32'(iq_full), 32'(cnt == 4'd8));
        check("iq_empty", 32'(iq_empty), 32'(cnt == 4'd0));
        check("issue_valid", 32'(issue_valid), 32'(iv));
        if (iv) check("issue_idx", 32'(issue_idx), 32'(idx));
    endtask

    initial begin
        reset = 1'b1;  flush = 1'b0;  enq_valid = 1'b0;  iq_entries_ready_to_go = '0;
        oldest_found = 1'b0;  oldest_idx_oh = '0;  issue_ready = 1'b0;

        for (int k = 0; k < 8; k++) begin
            vecs[k] = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0,
                         1'b1, 8'(1 << k), 3'(k), 1'b0, 3'd0, 8'h00,
                         4'(k + 1), 8'((1 << (k + 1)) - 1), 1'b0, 3'd0);
        end
        vecs[8]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0,  1'b0, 8'h00, 3'd0, 1'b0, 3'd0, 8'h00,  4'd8, 8'hff, 1'b0, 3'd0);
        vecs[9]  = mk(1'b1, 1'b0, 8'h20, 1'b1, 8'h20, 1'b1,  1'b0, 8'h00, 3'd0, 1'b1, 3'd5, 8'h20,  4'd7, 8'hdf, 1'b1, 3'd5);
        vecs[10] = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1,  1'b1, 8'h20, 3'd5, 1'b0, 3'd0, 8'h00,  4'd8, 8'hff, 1'b0, 3'd5);
        vecs[11] = mk(1'b0, 1'b0, 8'h0a, 1'b1, 8'h02, 1'b1,  1'b0, 8'h00, 3'd0, 1'b1, 3'd1, 8'h02,  4'd7, 8'hfd, 1'b1, 3'd1);
        vecs[12] = mk(1'b0, 1'b0, 8'h0a, 1'b1, 8'h04, 1'b1,  1'b1, 8'h00, 3'd1, 1'b0, 3'd0, 8'h00,  4'd7, 8'hfd, 1'b0, 3'd1);
        vecs[13] = mk(1'b1, 1'b0, 8'h02, 1'b1, 8'h02, 1'b1,  1'b1, 8'h02, 3'd1, 1'b0, 3'd0, 8'h00,  4'd8, 8'hff, 1'b0, 3'd1);

        // Reset: combinational outputs must stay quiet even with offers present.
        tick();
        tick();
        applyStimulus(1'b1, 1'b0, 8'h01, 1'b1, 8'h01, 1'b1);
        check("rst_enq_ready", 32'(enq_ready), 32'd0);
        check("rst_wren", 32'(iq_entries_wren_oh), 32'd0);
        check("rst_deq_fire", 32'(deq_fire), 32'd0);
        tick();
        checkState(4'd0, 8'h00, 1'b0, 3'd0);
        check("rst_issue_idx", 32'(issue_idx), 32'd0);
        reset = 1'b0;

        // Fill, full refusal, full with deq+enq, oldest-ready issue, masking.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].enq_valid, vecs[i].flush, vecs[i].rtg,
                          vecs[i].found, vecs[i].oldest, vecs[i].issue_ready);
            checkOutput(vecs[i]);
            tick();
            checkState(vecs[i].x_count, vecs[i].x_valid, vecs[i].x_issue_valid, vecs[i].x_issue_idx);
        end

        // Backpressure: issue slot 3, then hold with issue_ready low.
        applyStimulus(1'b0, 1'b0, 8'h08, 1'b1, 8'h08, 1'b0);
        check("bp_first_fire", 32'(deq_fire), 32'd1);
        check("bp_first_ptr", 32'(deq_ptr), 32'd3);
        tick();
        checkState(4'd7, 8'hf7, 1'b1, 3'd3);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b0, 8'h10, 1'b1, 8'h10, 1'b0);
            check("bp_hold_fire", 32'(deq_fire), 32'd0);
            check("bp_hold_clear", 32'(iq_entries_clear_entry), 32'd0);
            tick();
            checkState(4'd7, 8'hf7, 1'b1, 3'd3);
        end
        applyStimulus(1'b0, 1'b0, 8'h10, 1'b1, 8'h10, 1'b1);
        check("bp_release_fire", 32'(deq_fire), 32'd1);
        check("bp_release_ptr", 32'(deq_ptr), 32'd4);
        tick();
        checkState(4'd6, 8'he7, 1'b1, 3'd4);
        applyStimulus(1'b0, 1'b0, 8'h01, 1'b1, 8'h01, 1'b1);
        check("b2b_ptr", 32'(deq_ptr), 32'd0);
        tick();
        checkState(4'd5, 8'he6, 1'b1, 3'd0);

        // Flush with an offer and a candidate in the same cycle.
        applyStimulus(1'b1, 1'b1, 8'h02, 1'b1, 8'h02, 1'b1);
        check("fl_enq_ready", 32'(enq_ready), 32'd0);
        check("fl_wren", 32'(iq_entries_wren_oh), 32'd0);
        check("fl_clear", 32'(iq_entries_clear_entry), 32'd0);
        check("fl_deq_fire", 32'(deq_fire), 32'd0);
        tick();
        checkState(4'd0, 8'h00, 1'b0, 3'd0);

        // Refill to 7, issue slot 2 and leave it held: count 6, issue valid.
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
            check("refill_ptr", 32'(enq_ptr), 32'(k));
            tick();
        end
        applyStimulus(1'b0, 1'b0, 8'h04, 1'b1, 8'h04, 1'b0);
        check("pre_rst_ptr", 32'(deq_ptr), 32'd2);
        tick();
        checkState(4'd6, 8'h7b, 1'b1, 3'd2);

        // Reset mid-traffic.
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h08, 1'b1, 8'h08, 1'b1);
        check("mid_rst_enq_ready", 32'(enq_ready), 32'd0);
        check("mid_rst_deq_fire", 32'(deq_fire), 32'd0);
        check("mid_rst_clear", 32'(iq_entries_clear_entry), 32'd0);
        tick();
        checkState(4'd0, 8'h00, 1'b0, 3'd0);
        check("mid_rst_issue_idx", 32'(issue_idx), 32'd0);
        reset = 1'b0;

        // Enqueue in N, dequeue that entry in N+1 alongside another enqueue.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        check("post_enq_ptr", 32'(enq_ptr), 32'd0);
        tick();
        checkState(4'd1, 8'h01, 1'b0, 3'd0);
        applyStimulus(1'b1, 1'b0, 8'h01, 1'b1, 8'h01, 1'b1);
        check("both_wren", 32'(iq_entries_wren_oh), 32'h02);
        check("both_deq_fire", 32'(deq_fire), 32'd1);
        check("both_deq_ptr", 32'(deq_ptr), 32'd0);
        tick();
        checkState(4'd1, 8'h02, 1'b1, 3'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        checkState(4'd1, 8'h02, 1'b0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
